// File: rtl/systolic_pkg.sv
// ============================================================================
// systolic_pkg : shared sizing, Q4.4 element and matrix types for the
//                systolic array and its result drain.  Rev 1.0
// ============================================================================
`default_nettype none

package systolic_pkg;

   localparam int N      = 4;
   localparam int DATA_W = 8;

   typedef logic signed [DATA_W-1:0] q44_t;
   typedef q44_t [N-1:0][N-1:0]      mat_t;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } drain_state_e;

endpackage

`default_nettype wire

// File: rtl/systolic_result_drain_if.sv
// ============================================================================
// systolic_result_drain_if : result capture and element stream bundle of the
//                            result drain.  Rev 1.0
// ============================================================================
`default_nettype none

interface systolic_result_drain_if #(
   parameter int N      = 4,
   parameter int DATA_W = 8
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0][N-1:0][DATA_W-1:0] i_c;
   logic                            i_valid_result;
   logic [DATA_W-1:0]               o_data;
   logic                            o_valid;
   logic                            i_ready;
   logic [IW-1:0]                   o_row;
   logic [IW-1:0]                   o_col;
   logic                            o_last;
   logic                            o_space;
   logic                            o_overflow;

   // master: array + consumer side; slave: the drain itself
   modport master (
      output i_c, i_valid_result, i_ready,
      input  o_data, o_valid, o_row, o_col, o_last, o_space, o_overflow
   );

   modport slave (
      input  i_c, i_valid_result, i_ready,
      output o_data, o_valid, o_row, o_col, o_last, o_space, o_overflow
   );

endinterface

`default_nettype wire

// File: rtl/relu_q44.sv
// ============================================================================
// relu_q44 : combinational ReLU on a signed Q4.4 element (pass-through when
//            disabled).  Rev 1.0
// ============================================================================
`default_nettype none

module relu_q44 #(
   parameter int DATA_W  = 8,
   parameter bit RELU_EN = 1'b1
) (
   input  wire  [DATA_W-1:0] i_x,
   output logic [DATA_W-1:0] o_y
);

   assign o_y = (RELU_EN && i_x[DATA_W-1]) ? '0 : i_x;

endmodule

`default_nettype wire

// File: rtl/systolic_result_drain.sv
// ============================================================================
// systolic_result_drain : double-buffers result matrices from the systolic
//                         array and streams them row-major with handshake.
// Rev 1.0
// ============================================================================
`default_nettype none

module systolic_result_drain #(
   parameter int N       = systolic_pkg::N,
   parameter int DATA_W  = systolic_pkg::DATA_W,
   parameter bit RELU_EN = 1'b1
) (
   input wire i_clk,
   input wire i_arst_n,
   systolic_result_drain_if.slave bus
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] c_IDX_MAX = IW'(N - 1);

   logic [N-1:0][N-1:0][DATA_W-1:0] r_slot [2];
   logic [1:0]                      r_full;
   logic                            r_wptr;
   logic                            r_rptr;
   logic [IW-1:0]                   r_row;
   logic [IW-1:0]                   r_col;
   logic                            r_overflow;

   systolic_pkg::drain_state_e r_state;
   systolic_pkg::drain_state_e w_state_nxt;

   logic              w_valid;
   logic              w_last;
   logic              w_xfer;
   logic              w_done;
   logic              w_cap;
   logic              w_drop;
   logic              w_next_full;
   logic [1:0]        w_full_nxt;
   logic [DATA_W-1:0] w_elem;
   logic [DATA_W-1:0] w_relu;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_state <= systolic_pkg::ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_valid     = (r_state == systolic_pkg::ST_STREAM);
      w_last      = w_valid && (r_row == c_IDX_MAX) && (r_col == c_IDX_MAX);
      w_xfer      = w_valid && bus.i_ready;
      w_done      = w_xfer && w_last;
      // A slot being released at this edge can take a new matrix at the same edge
      w_cap       = bus.i_valid_result && (!r_full[r_wptr] || (w_done && (r_rptr == r_wptr)));
      w_drop      = bus.i_valid_result && !w_cap;
      w_next_full = r_full[~r_rptr] || (w_cap && (r_wptr != r_rptr));

      w_full_nxt = r_full;
      if (w_done) begin
         w_full_nxt[r_rptr] = 1'b0;
      end
      if (w_cap) begin
         w_full_nxt[r_wptr] = 1'b1;
      end

      case (r_state)
         systolic_pkg::ST_IDLE: begin
            // Entering on the capture edge gives first-cycle o_valid
            if (r_full[r_rptr] || (w_cap && (r_wptr == r_rptr))) begin
               w_state_nxt = systolic_pkg::ST_STREAM;
            end
         end
         systolic_pkg::ST_STREAM: begin
            if (w_done && !w_next_full) begin
               w_state_nxt = systolic_pkg::ST_IDLE;
            end
         end
         default: w_state_nxt = systolic_pkg::ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_full     <= 2'b00;
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
         r_row      <= '0;
         r_col      <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_full <= w_full_nxt;
         if (w_cap) begin
            r_wptr <= ~r_wptr;
         end
         if (w_done) begin
            r_rptr <= ~r_rptr;
         end
         if (w_xfer) begin
            if (r_col == c_IDX_MAX) begin
               r_col <= '0;
               r_row <= w_last ? '0 : r_row + IW'(1);
            end else begin
               r_col <= r_col + IW'(1);
            end
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Payload needs no reset: full flags alone decide what is live
   always_ff @(posedge i_clk) begin
      if (w_cap) begin
         r_slot[r_wptr] <= bus.i_c;
      end
   end

   assign w_elem = r_slot[r_rptr][r_row][r_col];

   relu_q44 #(
      .DATA_W  (DATA_W),
      .RELU_EN (RELU_EN)
   ) u_relu (
      .i_x (w_elem),
      .o_y (w_relu)
   );

   assign bus.o_data     = w_valid ? w_relu : '0;
   assign bus.o_valid    = w_valid;
   assign bus.o_row      = r_row;
   assign bus.o_col      = r_col;
   assign bus.o_last     = w_last;
   assign bus.o_space    = ~(r_full[0] & r_full[1]);
   assign bus.o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
// ============================================================================
// tb_systolic_result_drain : directed self-checking bench for the result drain
//                            (ReLU on and off instances).  Rev 1.0
// ============================================================================
`default_nettype none

module tb_systolic_result_drain;

   localparam int N  = 4;
   localparam int DW = 8;

   logic clk;
   logic arst_n;
   int   n_cmp;
   int   n_bad;

   systolic_result_drain_if #(.N(N), .DATA_W(DW)) if1 ();
   systolic_result_drain_if #(.N(N), .DATA_W(DW)) if0 ();

   assign if0.i_c            = if1.i_c;
   assign if0.i_valid_result = if1.i_valid_result;
   assign if0.i_ready        = if1.i_ready;

   systolic_result_drain #(.N(N), .DATA_W(DW), .RELU_EN(1'b1)) u_dut (
      .i_clk    (clk),
      .i_arst_n (arst_n),
      .bus      (if1)
   );

   systolic_result_drain #(.N(N), .DATA_W(DW), .RELU_EN(1'b0)) u_dut_raw (
      .i_clk    (clk),
      .i_arst_n (arst_n),
      .bus      (if0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_relu(input logic [7:0] v, input bit en);
      return (en && v[7]) ? 8'h00 : v;
   endfunction

   function automatic systolic_pkg::mat_t mk_const(input logic [7:0] v);
      systolic_pkg::mat_t m;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            m[r][c] = v;
      return m;
   endfunction

   function automatic systolic_pkg::mat_t mk_pat(input logic [7:0] base);
      systolic_pkg::mat_t m;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            m[r][c] = base + 8'(r * 16 + c);
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input systolic_pkg::mat_t m);
      if1.i_c            = m;
      if1.i_valid_result = 1'b1;
      tick();
      if1.i_valid_result = 1'b0;
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(if1.o_valid), 32'd0);
      chk("rst_space", 32'(if1.o_space), 32'd1);
      chk("rst_ovf", 32'(if1.o_overflow), 32'd0);
      tick();
      arst_n = 1'b1;
      tick();
   endtask

   // Walks nx elements of m; optional capture of mc coincident with the final transfer
   task automatic run_stream(input string tag, input systolic_pkg::mat_t m, input bit tog,
                             input int nx, input bit inj, input systolic_pkg::mat_t mc);
      int  k;
      int  cyc;
      int  r;
      int  c;
      bit  rdy;
      k   = 0;
      cyc = 0;
      while (k < nx) begin
         if (cyc >= 100) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            break;
         end
         rdy = tog ? ((cyc % 2) == 0) : 1'b1;
         if1.i_ready = rdy;
         r = k / N;
         c = k % N;
         if1.i_valid_result = inj && rdy && (k == N * N - 1);
         if (inj && rdy && (k == N * N - 1)) if1.i_c = mc;
         chk({tag, "_valid"}, 32'(if1.o_valid), 32'd1);
         chk({tag, "_row"}, 32'(if1.o_row), 32'(r));
         chk({tag, "_col"}, 32'(if1.o_col), 32'(c));
         chk({tag, "_last"}, 32'(if1.o_last), (k == N * N - 1) ? 32'd1 : 32'd0);
         chk({tag, "_data"}, 32'(if1.o_data), 32'(exp_relu(m[r][c], 1'b1)));
         chk({tag, "_raw"}, 32'(if0.o_data), 32'(exp_relu(m[r][c], 1'b0)));
         if (rdy && if1.o_valid) k++;
         tick();
         cyc++;
      end
      if1.i_valid_result = 1'b0;
   endtask

   systolic_pkg::mat_t ma, mb, mc, md, mz;

   initial begin
      n_cmp              = 0;
      n_bad              = 0;
      arst_n             = 1'b0;
      if1.i_c            = '0;
      if1.i_valid_result = 1'b0;
      if1.i_ready        = 1'b1;
      mz                 = '0;
      #12;
      chk("rst_valid", 32'(if1.o_valid), 32'd0);
      chk("rst_last", 32'(if1.o_last), 32'd0);
      chk("rst_ovf", 32'(if1.o_overflow), 32'd0);
      chk("rst_row", 32'(if1.o_row), 32'd0);
      chk("rst_col", 32'(if1.o_col), 32'd0);
      chk("rst_data", 32'(if1.o_data), 32'd0);
      chk("rst_space", 32'(if1.o_space), 32'd1);
      tick();
      arst_n = 1'b1;
      tick();

      // Uniform 0x10 matrix, consumer always ready
      ma = mk_const(8'h10);
      pulse(ma);
      chk("lat_valid", 32'(if1.o_valid), 32'd1);
      run_stream("const", ma, 1'b0, N * N, 1'b0, mz);
      chk("const_end", 32'(if1.o_valid), 32'd0);

      // Negative element [1][2] = 0xF0
      mb = mk_pat(8'h00);
      mb[1][2] = 8'hF0;
      pulse(mb);
      run_stream("relu", mb, 1'b0, N * N, 1'b0, mz);
      chk("relu_end", 32'(if1.o_valid), 32'd0);

      // Ready toggling every cycle, with a few negatives
      mc = mk_pat(8'h05);
      mc[0][3] = 8'h81;
      mc[3][3] = 8'h9C;
      pulse(mc);
      run_stream("tog", mc, 1'b1, N * N, 1'b0, mz);
      chk("tog_end", 32'(if1.o_valid), 32'd0);

      // Overflow: three pulses two cycles apart while stalled
      if1.i_ready = 1'b0;
      ma = mk_pat(8'h01);
      mb = mk_pat(8'h02);
      mc = mk_pat(8'h0C);
      pulse(ma);
      tick();
      pulse(mb);
      chk("ovf_space", 32'(if1.o_space), 32'd0);
      chk("ovf_pre", 32'(if1.o_overflow), 32'd0);
      tick();
      pulse(mc);
      chk("ovf_flag", 32'(if1.o_overflow), 32'd1);
      run_stream("ovfA", ma, 1'b0, N * N, 1'b0, mz);
      run_stream("ovfB", mb, 1'b0, N * N, 1'b0, mz);
      chk("ovf_end", 32'(if1.o_valid), 32'd0);
      chk("ovf_sticky", 32'(if1.o_overflow), 32'd1);
      do_reset();

      // Capture coincident with final transfer while both slots full
      if1.i_ready = 1'b0;
      ma = mk_pat(8'h03);
      mb = mk_pat(8'h04);
      mc = mk_pat(8'h08);
      pulse(ma);
      pulse(mb);
      chk("coin_space", 32'(if1.o_space), 32'd0);
      run_stream("coinA", ma, 1'b0, N * N, 1'b1, mc);
      chk("coin_ovf", 32'(if1.o_overflow), 32'd0);
      chk("coin_space2", 32'(if1.o_space), 32'd0);
      run_stream("coinB", mb, 1'b0, N * N, 1'b0, mz);
      run_stream("coinC", mc, 1'b0, N * N, 1'b0, mz);
      chk("coin_end", 32'(if1.o_valid), 32'd0);
      chk("coin_ovf2", 32'(if1.o_overflow), 32'd0);

      // Reset mid-stream after five transfers
      ma = mk_pat(8'h06);
      pulse(ma);
      run_stream("mid", ma, 1'b0, 5, 1'b0, mz);
      arst_n = 1'b0;
      #1;
      chk("mid_valid", 32'(if1.o_valid), 32'd0);
      chk("mid_row", 32'(if1.o_row), 32'd0);
      chk("mid_col", 32'(if1.o_col), 32'd0);
      tick();
      arst_n = 1'b1;
      tick();
      tick();
      chk("mid_noresume", 32'(if1.o_valid), 32'd0);
      md = mk_pat(8'h0A);
      pulse(md);
      run_stream("post", md, 1'b0, N * N, 1'b0, mz);
      chk("post_end", 32'(if1.o_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 Parameter N, default 4: matrix dimension, identical to the systolic array's N.
REQ-002 Parameter DATA_W, default 8: element width, signed Q4.4.
REQ-003 Parameter RELU_EN, default 1: 1 applies ReLU to each streamed element; 0 passes elements unmodified.
REQ-004 i_clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 i_arst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_c  input  N*N*DATA_W  result matrix from the systolic array, packed [N-1:0][N-1:0][DATA_W-1:0].
REQ-007 i_valid_result  input  1  one-cycle pulse; i_c is valid in that cycle.
REQ-008 o_data  output  DATA_W  streamed element.
REQ-009 o_valid  output  1  o_data, o_row, o_col and o_last are valid.
REQ-010 i_ready  input  1  consumer accepts the element.
REQ-011 o_row, o_col  output  $clog2(N) each  indices of the element on o_data.
REQ-012 o_last  output  1  high with element [N-1][N-1].
REQ-013 o_space  output  1  at least one buffer slot is free.
REQ-014 o_overflow  output  1  sticky flag; a result arrived while both slots were full.

Function
REQ-015 The block SHALL hold two matrix slots in ping-pong order, with 1-bit write and read pointers and per-slot full flags.
REQ-016 On a rising edge with i_valid_result=1 and the write slot free, the block SHALL copy i_c into the write slot, set its full flag and toggle the write pointer.
REQ-017 On i_valid_result=1 with both slots full, the block SHALL drop the matrix, set o_overflow, and leave slot contents unchanged.
REQ-018 A transfer SHALL occur on each edge where o_valid=1 and i_ready=1.
REQ-019 Elements SHALL stream in row-major order [0][0], [0][1] … [N-1][N-1], one per transfer.
REQ-020 The read FSM SHALL have two states.
- IDLE: o_valid=0; moves to STREAM when the read slot is full.
- STREAM: o_valid=1; after the last transfer, clears the slot's full flag and toggles the read pointer; stays in STREAM if the other slot is full, otherwise returns to IDLE.
REQ-021 Latency: with both slots empty, o_valid SHALL rise in the first cycle after the capture edge, presenting [0][0].
REQ-022 While o_valid=1 and i_ready=0, o_data, o_row, o_col and o_last SHALL hold stable.
REQ-023 Back-to-back streams SHALL have no bubble: the transfer after the last element of one slot presents [0][0] of the next full slot.
REQ-024 Simultaneous capture and final transfer while both slots are full: the capture SHALL be accepted into the slot freed at that edge, with no overflow.
REQ-025 When RELU_EN=1, o_data SHALL be 0 if the signed element is negative, else the element unchanged; no other arithmetic is performed.
REQ-026 o_space SHALL equal NOT(both full flags set), evaluated combinationally from the registered flags.

Reset
REQ-027 While i_arst_n=0, the block SHALL hold:
- FSM in IDLE, both pointers 0, both full flags 0, element counter 0;
- o_valid=0, o_last=0, o_overflow=0, o_row=0, o_col=0, o_data=0, o_space=1.
REQ-028 Reset asserted mid-stream SHALL discard all buffered data; no partial stream resumes after release.

Structure
REQ-029 N, DATA_W, the Q4.4 element typedef and the matrix typedef SHALL live in a shared package (systolic_pkg) used by both this block and the array.
REQ-030 The ReLU SHALL be one combinational sub-module, relu_q44, instantiated on the output path.

Verification
REQ-031 Single matrix, every element 8'h10, i_ready=1: 16 transfers of 8'h10, o_last only on the 16th, then o_valid=0.
REQ-032 Element [1][2]=8'hF0 with RELU_EN=1: 8'h00 emitted at row 1, col 2; with RELU_EN=0: 8'hF0 emitted.
REQ-033 i_ready toggling 1/0 every cycle: all 16 elements in order, outputs held stable in stall cycles.
REQ-034 Three pulses 2 cycles apart with i_ready=0: first two captured, o_space=0, third dropped with o_overflow=1; release i_ready: 32 transfers of the first two matrices only.
REQ-035 Both slots full, third pulse coincident with the final transfer of slot 0: capture accepted, o_overflow stays 0, 48 transfers total.
REQ-036 i_arst_n pulled low after 5 transfers: o_valid=0 immediately; after release, a new matrix streams from [0][0].
